rs_issue_scheduler: RTL and testbench

Reservation-station scheduler between rename/dispatch and the functional units. Holds up to RS_DEPTH dispatched entries, tracks source-operand readiness by snooping CDB broadcasts of physical register tags, and each cycle selects the oldest ready entry per functional-unit port with a valid/ready handshake. Produces the `rs_full` back-pressure that gates instruction-queue pops in dispatch.

---
 rtl/rs_issue_scheduler.sv | 174 +++++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_scheduler.sv
// Reservation-station scheduler: allocates dispatched entries, wakes sources from CDB tags,
// and offers the oldest ready entry to each functional-unit port via valid/ready.
module rs_issue_scheduler #(
    parameter  int SS         = 2,
    parameter  int RS_DEPTH   = 8,
    parameter  int PR_ENTRIES = 64,
    parameter  int CDB_PORTS  = 2,
    parameter  int NUM_FU     = 2,
    parameter  int PAYLOAD_W  = 64,
    localparam int PRW        = $clog2(PR_ENTRIES),
    localparam int FUW        = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int CW         = $clog2(RS_DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [SS-1:0]                       dispatch_valid,
    input  logic [SS-1:0][PRW-1:0]              dispatch_rs1,
    input  logic [SS-1:0][PRW-1:0]              dispatch_rs2,
    input  logic [SS-1:0]                       dispatch_rs1_rdy,
    input  logic [SS-1:0]                       dispatch_rs2_rdy,
    input  logic [SS-1:0][FUW-1:0]              dispatch_fu,
    input  logic [SS-1:0][PAYLOAD_W-1:0]        dispatch_payload,
    output logic                                rs_full,
    output logic [CW-1:0]                       free_count,
    input  logic [CDB_PORTS-1:0]                cdb_valid,
    input  logic [CDB_PORTS-1:0][PRW-1:0]       cdb_preg,
    output logic [NUM_FU-1:0]                   issue_valid,
    input  logic [NUM_FU-1:0]                   issue_ready,
    output logic [NUM_FU-1:0][PAYLOAD_W-1:0]    issue_payload,
    output logic [NUM_FU-1:0][PRW-1:0]          issue_rs1,
    output logic [NUM_FU-1:0][PRW-1:0]          issue_rs2
);

    logic [RS_DEPTH-1:0]                 valid_q, rs1_rdy_q, rs2_rdy_q, ready;
    logic [RS_DEPTH-1:0][PRW-1:0]        rs1_q, rs2_q;
    logic [RS_DEPTH-1:0][FUW-1:0]        fu_q;
    logic [RS_DEPTH-1:0][PAYLOAD_W-1:0]  payload_q;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0]   older_q;

    logic [NUM_FU-1:0][RS_DEPTH-1:0]     sel_oh;
    logic [SS-1:0][RS_DEPTH-1:0]         alloc_oh, alloc_prior;
    logic [RS_DEPTH-1:0]                 alloc_taken, wake1, wake2;
    logic                                alloc_found;
    logic [SS-1:0]                       byp1, byp2;
    logic [CW-1:0]                       valid_cnt;

    assign ready = valid_q & rs1_rdy_q & rs2_rdy_q;

    // An entry is selected when it is ready for port f and no older ready entry targets f.
    always_comb begin
        sel_oh = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (ready[i] && fu_q[i] == FUW'(f)) begin
                    sel_oh[f][i] = 1'b1;
                    for (int j = 0; j < RS_DEPTH; j++) begin
                        if (ready[j] && fu_q[j] == FUW'(f) && older_q[j][i])
                            sel_oh[f][i] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        issue_valid   = '0;
        issue_payload = '0;
        issue_rs1     = '0;
        issue_rs2     = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            issue_valid[f] = |sel_oh[f];
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (sel_oh[f][i]) begin
                    issue_payload[f] = payload_q[i];
                    issue_rs1[f]     = rs1_q[i];
                    issue_rs2[f]     = rs2_q[i];
                end
            end
        end
    end

    always_comb begin
        valid_cnt = '0;
        for (int i = 0; i < RS_DEPTH; i++)
            valid_cnt = valid_cnt + CW'(valid_q[i]);
    end

    assign free_count = CW'(RS_DEPTH) - valid_cnt;
    assign rs_full    = free_count < CW'(SS);

    // Lane l claims the l-th lowest free slot; alloc_prior records slots claimed by lower lanes.
    always_comb begin
        alloc_oh    = '0;
        alloc_prior = '0;
        alloc_taken = '0;
        alloc_found = 1'b0;
        for (int l = 0; l < SS; l++) begin
            alloc_prior[l] = alloc_taken;
            alloc_found    = 1'b0;
            if (dispatch_valid[l] && !rs_full) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (!alloc_found && !valid_q[i] && !alloc_taken[i]) begin
                        alloc_oh[l][i] = 1'b1;
                        alloc_taken[i] = 1'b1;
                        alloc_found    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        byp1  = '0;
        byp2  = '0;
        wake1 = '0;
        wake2 = '0;
        for (int c = 0; c < CDB_PORTS; c++) begin
            for (int l = 0; l < SS; l++) begin
                if (cdb_valid[c] && cdb_preg[c] == dispatch_rs1[l]) byp1[l] = 1'b1;
                if (cdb_valid[c] && cdb_preg[c] == dispatch_rs2[l]) byp2[l] = 1'b1;
            end
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (cdb_valid[c] && cdb_preg[c] == rs1_q[i]) wake1[i] = 1'b1;
                if (cdb_valid[c] && cdb_preg[c] == rs2_q[i]) wake2[i] = 1'b1;
            end
        end
    end

    // Row writes skip same-cycle allocations so their relative age comes only from column writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            older_q   <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (wake1[i]) rs1_rdy_q[i] <= 1'b1;
                if (wake2[i]) rs2_rdy_q[i] <= 1'b1;
                for (int f = 0; f < NUM_FU; f++) begin
                    if (sel_oh[f][i] && issue_ready[f]) valid_q[i] <= 1'b0;
                end
                for (int l = 0; l < SS; l++) begin
                    if (alloc_oh[l][i]) begin
                        valid_q[i]   <= 1'b1;
                        rs1_rdy_q[i] <= dispatch_rs1_rdy[l] | byp1[l];
                        rs2_rdy_q[i] <= dispatch_rs2_rdy[l] | byp2[l];
                        for (int j = 0; j < RS_DEPTH; j++) begin
                            older_q[j][i] <= valid_q[j] | alloc_prior[l][j];
                            if (!alloc_taken[j]) older_q[i][j] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int l = 0; l < SS; l++) begin
                if (alloc_oh[l][i]) begin
                    rs1_q[i]     <= dispatch_rs1[l];
                    rs2_q[i]     <= dispatch_rs2[l];
                    fu_q[i]      <= dispatch_fu[l];
                    payload_q[i] <= dispatch_payload[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: table of per-cycle vectors plus hand-written
// sequences for fill/back-pressure, issue hold, flush and mid-operation reset.
module tb_rs_issue_scheduler;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush;
    logic [1:0]           dispatch_valid;
    logic [1:0][5:0]      dispatch_rs1, dispatch_rs2;
    logic [1:0]           dispatch_rs1_rdy, dispatch_rs2_rdy;
    logic [1:0][0:0]      dispatch_fu;
    logic [1:0][63:0]     dispatch_payload;
    logic                 rs_full;
    logic [3:0]           free_count;
    logic [1:0]           cdb_valid;
    logic [1:0][5:0]      cdb_preg;
    logic [1:0]           issue_valid;
    logic [1:0]           issue_ready;
    logic [1:0][63:0]     issue_payload;
    logic [1:0][5:0]      issue_rs1, issue_rs2;

    always #5 clk = ~clk;

    rs_issue_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .dispatch_valid   (dispatch_valid),
        .dispatch_rs1     (dispatch_rs1),
        .dispatch_rs2     (dispatch_rs2),
        .dispatch_rs1_rdy (dispatch_rs1_rdy),
        .dispatch_rs2_rdy (dispatch_rs2_rdy),
        .dispatch_fu      (dispatch_fu),
        .dispatch_payload (dispatch_payload),
        .rs_full          (rs_full),
        .free_count       (free_count),
        .cdb_valid        (cdb_valid),
        .cdb_preg         (cdb_preg),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_payload    (issue_payload),
        .issue_rs1        (issue_rs1),
        .issue_rs2        (issue_rs2)
    );

    typedef struct packed {
        logic [5:0]  rs1;
        logic        r1;
        logic [5:0]  rs2;
        logic        r2;
        logic        fu;
        logic [63:0] pay;
    } lane_t;

    // Each row: expected outputs observed this cycle, then inputs driven into the next edge.
    typedef struct {
        logic        flush;
        logic [1:0]  dv;
        lane_t       l0, l1;
        logic [1:0]  cv;
        logic [5:0]  c0, c1;
        logic [1:0]  ir;
        logic [1:0]  e_iv;
        logic [3:0]  e_free;
        logic        e_full;
        logic [63:0] e_p0, e_p1;
    } vec_t;

    vec_t  vecs[$];
    lane_t nl;
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic lane_t ln(input logic [5:0] rs1, input logic r1, input logic [5:0] rs2,
                                 input logic r2, input logic fu, input logic [63:0] pay);
        lane_t l;
        l.rs1 = rs1; l.r1 = r1; l.rs2 = rs2; l.r2 = r2; l.fu = fu; l.pay = pay;
        return l;
    endfunction

    function automatic lane_t nr(input logic [63:0] pay);
        return ln(6'd5, 1'b0, 6'd5, 1'b1, 1'b0, pay);
    endfunction

    function automatic lane_t rd1(input logic [63:0] pay);
        return ln(6'd1, 1'b1, 6'd2, 1'b1, 1'b1, pay);
    endfunction

    task automatic add(input logic [1:0] e_iv, input logic [3:0] e_free, input logic e_full,
                       input logic [63:0] e_p0, input logic [63:0] e_p1,
                       input logic fl, input logic [1:0] dv, input lane_t l0, input lane_t l1,
                       input logic [1:0] cv, input logic [5:0] c0, input logic [5:0] c1,
                       input logic [1:0] ir);
        vec_t v;
        v.e_iv = e_iv; v.e_free = e_free; v.e_full = e_full; v.e_p0 = e_p0; v.e_p1 = e_p1;
        v.flush = fl; v.dv = dv; v.l0 = l0; v.l1 = l1;
        v.cv = cv; v.c0 = c0; v.c1 = c1; v.ir = ir;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic fl, input logic [1:0] dv, input lane_t l0,
                                  input lane_t l1, input logic [1:0] cv, input logic [5:0] c0,
                                  input logic [5:0] c1, input logic [1:0] ir);
        flush               = fl;
        dispatch_valid      = dv;
        dispatch_rs1[0]     = l0.rs1;  dispatch_rs1[1]     = l1.rs1;
        dispatch_rs2[0]     = l0.rs2;  dispatch_rs2[1]     = l1.rs2;
        dispatch_rs1_rdy[0] = l0.r1;   dispatch_rs1_rdy[1] = l1.r1;
        dispatch_rs2_rdy[0] = l0.r2;   dispatch_rs2_rdy[1] = l1.r2;
        dispatch_fu[0]      = l0.fu;   dispatch_fu[1]      = l1.fu;
        dispatch_payload[0] = l0.pay;  dispatch_payload[1] = l1.pay;
        cdb_valid           = cv;
        cdb_preg[0]         = c0;
        cdb_preg[1]         = c1;
        issue_ready         = ir;
    endtask

    task automatic idle(input logic [1:0] ir);
        apply_stimulus(1'b0, 2'b00, nl, nl, 2'b00, 6'd0, 6'd0, ir);
    endtask

    task automatic check_output(input string name, input logic [1:0] e_iv, input logic [3:0] e_free,
                                input logic e_full, input logic [63:0] e_p0, input logic [63:0] e_p1);
        cmp({name, ".issue_valid"}, 64'(issue_valid), 64'(e_iv));
        cmp({name, ".free_count"}, 64'(free_count), 64'(e_free));
        cmp({name, ".rs_full"}, 64'(rs_full), 64'(e_full));
        if (e_iv[0]) cmp({name, ".payload0"}, issue_payload[0], e_p0);
        if (e_iv[1]) cmp({name, ".payload1"}, issue_payload[1], e_p1);
    endtask

    initial begin
        nl = '0;

        // Two-lane dispatch/issue, then CDB wakeup and age ordering on fu0.
        add(2'b00, 8, 0, 0, 0,          0, 2'b11, ln(1,1,2,1,0,'hA1), ln(3,1,4,1,1,'hB1), 2'b00, 0, 0, 2'b00);
        add(2'b11, 6, 0, 'hA1, 'hB1,    0, 2'b00, nl, nl, 2'b00, 0, 0, 2'b11);
        add(2'b00, 8, 0, 0, 0,          0, 2'b11, ln(12,0,2,1,0,'hA2), ln(7,1,8,1,0,'hB2), 2'b00, 0, 0, 2'b00);
        add(2'b01, 6, 0, 'hB2, 0,       0, 2'b00, nl, nl, 2'b01, 12, 0, 2'b01);
        add(2'b01, 7, 0, 'hA2, 0,       0, 2'b01, ln(9,1,10,1,0,'hC2), nl, 2'b00, 0, 0, 2'b00);
        add(2'b01, 6, 0, 'hA2, 0,       0, 2'b00, nl, nl, 2'b00, 0, 0, 2'b01);
        add(2'b01, 7, 0, 'hC2, 0,       0, 2'b00, nl, nl, 2'b00, 0, 0, 2'b01);
        // Same-cycle bypass on lane0 rs2; lane1 stays asleep until its own broadcast.
        add(2'b00, 8, 0, 0, 0,          0, 2'b11, ln(20,1,33,0,1,'hD3), ln(34,0,21,1,1,'hE3), 2'b10, 0, 33, 2'b00);
        add(2'b10, 6, 0, 0, 'hD3,       0, 2'b00, nl, nl, 2'b01, 34, 0, 2'b10);
        add(2'b10, 7, 0, 0, 'hE3,       0, 2'b00, nl, nl, 2'b00, 0, 0, 2'b10);
        add(2'b00, 8, 0, 0, 0,          0, 2'b00, nl, nl, 2'b00, 0, 0, 2'b00);

        idle(2'b00);
        flush = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            check_output($sformatf("row%0d", k), vecs[k].e_iv, vecs[k].e_free, vecs[k].e_full,
                         vecs[k].e_p0, vecs[k].e_p1);
            apply_stimulus(vecs[k].flush, vecs[k].dv, vecs[k].l0, vecs[k].l1,
                           vecs[k].cv, vecs[k].c0, vecs[k].c1, vecs[k].ir);
            @(negedge clk);
        end

        // Fill to 7 sleeping entries; further dispatch must be ignored while full.
        apply_stimulus(0, 2'b11, nr('h100), nr('h101), 2'b00, 0, 0, 2'b00);
        @(negedge clk);
        check_output("fill1", 2'b00, 6, 0, 0, 0);
        apply_stimulus(0, 2'b11, nr('h102), nr('h103), 2'b00, 0, 0, 2'b00);
        @(negedge clk);
        check_output("fill2", 2'b00, 4, 0, 0, 0);
        apply_stimulus(0, 2'b11, nr('h104), nr('h105), 2'b00, 0, 0, 2'b00);
        @(negedge clk);
        check_output("fill3", 2'b00, 2, 0, 0, 0);
        apply_stimulus(0, 2'b01, nr('h106), nl, 2'b00, 0, 0, 2'b00);
        @(negedge clk);
        check_output("full", 2'b00, 1, 1, 0, 0);
        apply_stimulus(0, 2'b11, nr('h1F0), nr('h1F1), 2'b00, 0, 0, 2'b00);
        @(negedge clk);
        check_output("full_ignored", 2'b00, 1, 1, 0, 0);
        apply_stimulus(0, 2'b00, nl, nl, 2'b01, 5, 0, 2'b00);
        @(negedge clk);
        check_output("wake_oldest", 2'b01, 1, 1, 'h100, 0);
        idle(2'b01);
        @(negedge clk);
        check_output("after_issue", 2'b01, 2, 0, 'h101, 0);
        idle(2'b00);

        // Offer held with issue_ready low must stay put and keep its slot.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output($sformatf("hold%0d", k), 2'b01, 2, 0, 'h101, 0);
            idle((k == 2) ? 2'b01 : 2'b00);
        end
        @(negedge clk);
        check_output("pre_flush", 2'b01, 3, 0, 'h102, 0);

        // Flush with concurrent dispatch and issue handshake discards everything.
        apply_stimulus(1, 2'b11, rd1('h2A0), rd1('h2A1), 2'b00, 0, 0, 2'b01);
        @(negedge clk);
        check_output("flush", 2'b00, 8, 0, 0, 0);
        idle(2'b00);
        @(negedge clk);
        check_output("flush_settled", 2'b00, 8, 0, 0, 0);

        // Reset while a handshake is in flight.
        apply_stimulus(0, 2'b01, ln(40,1,41,1,1,'h300), nl, 2'b00, 0, 0, 2'b00);
        @(negedge clk);
        check_output("pre_reset", 2'b10, 7, 0, 0, 'h300);
        cmp("pre_reset.issue_rs1", 64'(issue_rs1[1]), 64'd40);
        cmp("pre_reset.issue_rs2", 64'(issue_rs2[1]), 64'd41);
        rst = 1'b1;
        idle(2'b10);
        @(negedge clk);
        rst = 1'b0;
        idle(2'b00);
        check_output("mid_reset", 2'b00, 8, 0, 0, 0);
        @(negedge clk);
        check_output("post_reset", 2'b00, 8, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
